// File: rtl/bbox_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bbox_pkg
// Description : Shared types for the bounding-box frame sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package bbox_pkg;

    localparam int COUNT_W      = 8;
    // Record field widths track the sequencer's default coordinate widths.
    localparam int BBOX_LABEL_W = 6;
    localparam int BBOX_X_W     = 11;
    localparam int BBOX_Y_W     = 10;

    typedef enum logic [2:0] {
        ST_CLEAR  = 3'd0,
        ST_ACCEPT = 3'd1,
        ST_SCAN   = 3'd2,
        ST_CHK    = 3'd3,
        ST_EMIT   = 3'd4,
        ST_DONE   = 3'd5
    } seq_state_t;

    typedef struct packed {
        logic [BBOX_LABEL_W-1:0] label;
        logic [BBOX_X_W-1:0]     min_x;
        logic [BBOX_Y_W-1:0]     min_y;
        logic [BBOX_X_W-1:0]     max_x;
        logic [BBOX_Y_W-1:0]     max_y;
    } bbox_rec_t;

endpackage
`default_nettype wire

// File: rtl/bbox_size_filter.sv
`default_nettype none
// ============================================================================
// Module      : bbox_size_filter
// Description : Combinational minimum-size test for one bbox table entry.
// Revision    : 1.0 - initial release
// ============================================================================
module bbox_size_filter #(
    parameter int WIDTH_BITS  = 11,
    parameter int HEIGHT_BITS = 10
) (
    input  logic                   active,
    input  logic [WIDTH_BITS-1:0]  min_x,
    input  logic [WIDTH_BITS-1:0]  max_x,
    input  logic [HEIGHT_BITS-1:0] min_y,
    input  logic [HEIGHT_BITS-1:0] max_y,
    input  logic [WIDTH_BITS-1:0]  min_w,
    input  logic [HEIGHT_BITS-1:0] min_h,
    output logic                   pass
);

    // One extra bit so a full-frame span does not wrap to zero.
    logic [WIDTH_BITS:0]  w_span_x;
    logic [HEIGHT_BITS:0] w_span_y;

    assign w_span_x = {1'b0, max_x} - {1'b0, min_x} + (WIDTH_BITS+1)'(1);
    assign w_span_y = {1'b0, max_y} - {1'b0, min_y} + (HEIGHT_BITS+1)'(1);

    assign pass = active
                & (w_span_x >= {1'b0, min_w})
                & (w_span_y >= {1'b0, min_h});

endmodule
`default_nettype wire

// File: rtl/bbox_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : bbox_frame_sequencer
// Description : Per-frame clear / accept / scan sequencer with filtered,
//               backpressured bounding-box readout.
// Revision    : 1.0 - initial release
// ============================================================================
module bbox_frame_sequencer
    import bbox_pkg::*;
#(
    parameter int WIDTH_BITS  = 11,
    parameter int HEIGHT_BITS = 10,
    parameter int LABEL_WIDTH = 6,
    parameter int NUM_LABELS  = 1 << LABEL_WIDTH,
    parameter int MAX_BOXES   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pix_valid,
    input  logic                   pix_last,
    output logic                   pix_ready,
    output logic                   dp_enable,
    input  logic [WIDTH_BITS-1:0]  min_w,
    input  logic [HEIGHT_BITS-1:0] min_h,
    output logic                   tbl_rd_en,
    output logic [LABEL_WIDTH-1:0] tbl_addr,
    input  logic                   tbl_active,
    input  logic [WIDTH_BITS-1:0]  tbl_min_x,
    input  logic [WIDTH_BITS-1:0]  tbl_max_x,
    input  logic [HEIGHT_BITS-1:0] tbl_min_y,
    input  logic [HEIGHT_BITS-1:0] tbl_max_y,
    output logic                   tbl_clr_en,
    output logic                   box_valid,
    input  logic                   box_ready,
    output logic [LABEL_WIDTH-1:0] box_label,
    output logic [WIDTH_BITS-1:0]  box_min_x,
    output logic [WIDTH_BITS-1:0]  box_max_x,
    output logic [HEIGHT_BITS-1:0] box_min_y,
    output logic [HEIGHT_BITS-1:0] box_max_y,
    output logic                   frame_done,
    output logic [7:0]             box_count,
    output logic                   box_overflow
);

    localparam logic [LABEL_WIDTH-1:0] c_LAST_IDX  = LABEL_WIDTH'(NUM_LABELS - 1);
    localparam logic [COUNT_W-1:0]     c_MAX_BOXES = COUNT_W'(MAX_BOXES);

    seq_state_t             r_state, w_state_nxt;
    logic [LABEL_WIDTH-1:0] r_idx, w_idx_nxt;
    logic [COUNT_W-1:0]     r_count, w_count_nxt;
    logic                   r_ovf, w_ovf_nxt;
    logic [COUNT_W-1:0]     r_box_count, w_box_count_nxt;
    logic                   r_box_overflow, w_box_overflow_nxt;
    bbox_rec_t              r_box, w_box_nxt, w_rec;
    logic                   w_pass;
    logic                   w_advance;

    bbox_size_filter #(
        .WIDTH_BITS  (WIDTH_BITS),
        .HEIGHT_BITS (HEIGHT_BITS)
    ) u_size_filter (
        .active (tbl_active),
        .min_x  (tbl_min_x),
        .max_x  (tbl_max_x),
        .min_y  (tbl_min_y),
        .max_y  (tbl_max_y),
        .min_w  (min_w),
        .min_h  (min_h),
        .pass   (w_pass)
    );

    assign w_rec.label = BBOX_LABEL_W'(r_idx);
    assign w_rec.min_x = BBOX_X_W'(tbl_min_x);
    assign w_rec.min_y = BBOX_Y_W'(tbl_min_y);
    assign w_rec.max_x = BBOX_X_W'(tbl_max_x);
    assign w_rec.max_y = BBOX_Y_W'(tbl_max_y);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_CLEAR;
            r_idx          <= '0;
            r_count        <= '0;
            r_ovf          <= 1'b0;
            r_box_count    <= '0;
            r_box_overflow <= 1'b0;
            r_box          <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_idx          <= w_idx_nxt;
            r_count        <= w_count_nxt;
            r_ovf          <= w_ovf_nxt;
            r_box_count    <= w_box_count_nxt;
            r_box_overflow <= w_box_overflow_nxt;
            r_box          <= w_box_nxt;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_idx_nxt          = r_idx;
        w_count_nxt        = r_count;
        w_ovf_nxt          = r_ovf;
        w_box_count_nxt    = r_box_count;
        w_box_overflow_nxt = r_box_overflow;
        w_box_nxt          = r_box;
        w_advance          = 1'b0;
        pix_ready          = 1'b0;
        tbl_rd_en          = 1'b0;
        tbl_clr_en         = 1'b0;
        box_valid          = 1'b0;
        frame_done         = 1'b0;

        case (r_state)
            ST_CLEAR: begin
                tbl_clr_en = 1'b1;
                if (r_idx == c_LAST_IDX) begin
                    w_state_nxt = ST_ACCEPT;
                    w_idx_nxt   = '0;
                    w_count_nxt = '0;
                    w_ovf_nxt   = 1'b0;
                end else begin
                    w_idx_nxt = r_idx + LABEL_WIDTH'(1);
                end
            end
            ST_ACCEPT: begin
                pix_ready = 1'b1;
                if (pix_valid && pix_last) begin
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                tbl_rd_en   = 1'b1;
                w_state_nxt = ST_CHK;
            end
            ST_CHK: begin
                if (w_pass && (r_count < c_MAX_BOXES)) begin
                    w_box_nxt   = w_rec;
                    w_state_nxt = ST_EMIT;
                end else begin
                    if (w_pass) begin
                        w_ovf_nxt = 1'b1;
                    end
                    w_advance = 1'b1;
                end
            end
            ST_EMIT: begin
                box_valid = 1'b1;
                if (box_ready) begin
                    w_count_nxt = r_count + COUNT_W'(1);
                    w_advance   = 1'b1;
                end
            end
            ST_DONE: begin
                frame_done  = 1'b1;
                w_state_nxt = ST_CLEAR;
                w_idx_nxt   = '0;
            end
            default: begin
                w_state_nxt = ST_CLEAR;
                w_idx_nxt   = '0;
            end
        endcase

        // Results are latched on DONE entry so they hold until the next frame.
        if (w_advance) begin
            if (r_idx == c_LAST_IDX) begin
                w_state_nxt        = ST_DONE;
                w_box_count_nxt    = w_count_nxt;
                w_box_overflow_nxt = w_ovf_nxt;
            end else begin
                w_idx_nxt   = r_idx + LABEL_WIDTH'(1);
                w_state_nxt = ST_SCAN;
            end
        end
    end

    assign dp_enable    = pix_valid & pix_ready;
    assign tbl_addr     = r_idx;
    assign box_label    = LABEL_WIDTH'(r_box.label);
    assign box_min_x    = WIDTH_BITS'(r_box.min_x);
    assign box_max_x    = WIDTH_BITS'(r_box.max_x);
    assign box_min_y    = HEIGHT_BITS'(r_box.min_y);
    assign box_max_y    = HEIGHT_BITS'(r_box.max_y);
    assign box_count    = r_box_count;
    assign box_overflow = r_box_overflow;

endmodule
`default_nettype wire

// File: tb/tb_bbox_frame_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_bbox_frame_sequencer
// Description : Directed self-checking bench for bbox_frame_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bbox_frame_sequencer;

    localparam int LW = 6;
    localparam int XW = 11;
    localparam int YW = 10;
    localparam int NL = 64;
    localparam int MB = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pix_valid = 1'b0;
    logic          pix_last = 1'b0;
    logic          box_ready = 1'b0;
    logic [XW-1:0] min_w = '0;
    logic [YW-1:0] min_h = '0;

    logic          pix_ready, dp_enable, tbl_rd_en, tbl_clr_en;
    logic [LW-1:0] tbl_addr;
    logic          tbl_active = 1'b0;
    logic [XW-1:0] tbl_min_x = '0, tbl_max_x = '0;
    logic [YW-1:0] tbl_min_y = '0, tbl_max_y = '0;
    logic          box_valid, frame_done, box_overflow;
    logic [LW-1:0] box_label;
    logic [XW-1:0] box_min_x, box_max_x;
    logic [YW-1:0] box_min_y, box_max_y;
    logic [7:0]    box_count;

    always #5 clk = ~clk;

    bbox_frame_sequencer #(
        .WIDTH_BITS(XW), .HEIGHT_BITS(YW), .LABEL_WIDTH(LW),
        .NUM_LABELS(NL), .MAX_BOXES(MB)
    ) dut (
        .clk(clk), .rst(rst),
        .pix_valid(pix_valid), .pix_last(pix_last), .pix_ready(pix_ready),
        .dp_enable(dp_enable), .min_w(min_w), .min_h(min_h),
        .tbl_rd_en(tbl_rd_en), .tbl_addr(tbl_addr), .tbl_active(tbl_active),
        .tbl_min_x(tbl_min_x), .tbl_max_x(tbl_max_x),
        .tbl_min_y(tbl_min_y), .tbl_max_y(tbl_max_y), .tbl_clr_en(tbl_clr_en),
        .box_valid(box_valid), .box_ready(box_ready), .box_label(box_label),
        .box_min_x(box_min_x), .box_max_x(box_max_x),
        .box_min_y(box_min_y), .box_max_y(box_max_y),
        .frame_done(frame_done), .box_count(box_count), .box_overflow(box_overflow)
    );

    // Table model: one-cycle read latency; contents set directly by tasks.
    logic          t_act  [NL];
    logic [XW-1:0] t_minx [NL];
    logic [XW-1:0] t_maxx [NL];
    logic [YW-1:0] t_miny [NL];
    logic [YW-1:0] t_maxy [NL];

    always @(posedge clk) begin
        if (tbl_rd_en) begin
            tbl_active <= t_act[tbl_addr];
            tbl_min_x  <= t_minx[tbl_addr];
            tbl_max_x  <= t_maxx[tbl_addr];
            tbl_min_y  <= t_miny[tbl_addr];
            tbl_max_y  <= t_maxy[tbl_addr];
        end
    end

    int n_vec = 0;
    int n_err = 0;

    int            rec_n;
    logic [LW-1:0] rec_label [32];
    logic [XW-1:0] rec_minx  [32];
    logic [XW-1:0] rec_maxx  [32];
    logic [YW-1:0] rec_miny  [32];
    logic [YW-1:0] rec_maxy  [32];
    int            got_done;
    logic [7:0]    done_count;
    logic          done_ovf;
    int            held;
    int            changed;
    int            dp_cnt;

    task automatic clear_table();
        for (int i = 0; i < NL; i++) begin
            t_act[i] = 1'b0; t_minx[i] = '0; t_maxx[i] = '0; t_miny[i] = '0; t_maxy[i] = '0;
        end
    endtask

    task automatic set_entry(input int lbl, input int x0, input int x1, input int y0, input int y1);
        t_act[lbl] = 1'b1;
        t_minx[lbl] = XW'(x0); t_maxx[lbl] = XW'(x1);
        t_miny[lbl] = YW'(y0); t_maxy[lbl] = YW'(y1);
    endtask

    task automatic wait_accept();
        int ok;
        ok = 0;
        for (int c = 0; c < 400 && ok == 0; c++) begin
            @(negedge clk); #1;
            if (pix_ready === 1'b1) ok = 1;
        end
        n_vec++;
        if (ok == 0) begin
            n_err++;
            $display("FAIL wait_accept: pix_ready=%b after 400 cycles, required 1", pix_ready);
        end
    endtask

    task automatic send_frame(input int n, input bit hold);
        dp_cnt = 0;
        for (int p = 1; p <= n; p++) begin
            @(negedge clk);
            pix_valid = 1'b1;
            pix_last  = (p == n);
            #1;
            if (dp_enable === 1'b1) dp_cnt++;
        end
        @(negedge clk);
        pix_last  = 1'b0;
        pix_valid = hold;
        #1;
        n_vec++;
        if (pix_ready !== 1'b0 || dp_enable !== 1'b0) begin
            n_err++;
            $display("FAIL ready_after_last: pix_ready=%b dp_enable=%b, required 0 0", pix_ready, dp_enable);
        end
    endtask

    task automatic collect(input int stall);
        logic [LW-1:0] s_l;
        logic [XW-1:0] s_x0, s_x1;
        logic [YW-1:0] s_y0, s_y1;
        int seen;
        rec_n = 0; got_done = 0; held = 0; changed = 0; seen = 0;
        s_l = '0; s_x0 = '0; s_x1 = '0; s_y0 = '0; s_y1 = '0;
        for (int c = 0; c < 3000 && got_done == 0; c++) begin
            @(negedge clk);
            if (box_valid === 1'b1 && stall > 0) begin
                if (seen == 0) begin
                    s_l = box_label; s_x0 = box_min_x; s_x1 = box_max_x; s_y0 = box_min_y; s_y1 = box_max_y;
                    seen = 1;
                end else if ({box_label, box_min_x, box_max_x, box_min_y, box_max_y} !== {s_l, s_x0, s_x1, s_y0, s_y1}) begin
                    changed++;
                end
                box_ready = 1'b0;
                held++;
                stall--;
            end else begin
                box_ready = 1'b1;
            end
            #1;
            if (dp_enable === 1'b1) dp_cnt++;
            if (box_valid === 1'b1 && box_ready === 1'b1) begin
                if (seen == 1 && rec_n == 0 &&
                    {box_label, box_min_x, box_max_x, box_min_y, box_max_y} !== {s_l, s_x0, s_x1, s_y0, s_y1})
                    changed++;
                if (rec_n < 32) begin
                    rec_label[rec_n] = box_label;
                    rec_minx[rec_n] = box_min_x; rec_maxx[rec_n] = box_max_x;
                    rec_miny[rec_n] = box_min_y; rec_maxy[rec_n] = box_max_y;
                end
                rec_n++;
            end
            if (frame_done === 1'b1) begin
                got_done = 1; done_count = box_count; done_ovf = box_overflow;
            end
        end
        box_ready = 1'b0;
        n_vec++;
        if (got_done == 0) begin
            n_err++;
            $display("FAIL frame_done_timeout: frame_done not seen in 3000 cycles, required 1");
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        n_vec++;
        if ({box_valid, frame_done, pix_ready, tbl_rd_en, box_overflow} !== 5'b0 || box_count !== 8'd0) begin
            n_err++;
            $display("FAIL reset_outputs: valid/done/ready/rd/ovf=%b count=%0d, required 00000 0",
                     {box_valid, frame_done, pix_ready, tbl_rd_en, box_overflow}, box_count);
        end
        n_vec++;
        if ({box_label, box_min_x, box_max_x, box_min_y, box_max_y} !== '0) begin
            n_err++;
            $display("FAIL reset_box_fields: label=%0d min_x=%0d, required 0 0", box_label, box_min_x);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < NL; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            n_vec++;
            if (tbl_clr_en !== 1'b1 || tbl_addr !== LW'(k) || pix_ready !== 1'b0) begin
                n_err++;
                $display("FAIL clear_sweep: clr=%b addr=%0d ready=%b, required 1 %0d 0", tbl_clr_en, tbl_addr, pix_ready, k);
            end
        end
        @(negedge clk); #1;
        n_vec++;
        if (pix_ready !== 1'b1 || tbl_clr_en !== 1'b0) begin
            n_err++;
            $display("FAIL ready_cycle65: ready=%b clr=%b, required 1 0", pix_ready, tbl_clr_en);
        end
    endtask

    task automatic test_basic_filter(input int stall);
        wait_accept();
        clear_table();
        set_entry(3, 10, 19, 5, 9);
        set_entry(7, 0, 1, 0, 0);
        min_w = 11'd4; min_h = 10'd2;
        send_frame(5, 1'b0);
        collect(stall);
        n_vec++;
        if (rec_n !== 1) begin
            n_err++; $display("FAIL basic_rec_n: got %0d, required 1", rec_n);
        end
        n_vec++;
        if (rec_label[0] !== 6'd3 || rec_minx[0] !== 11'd10 || rec_miny[0] !== 10'd5 ||
            rec_maxx[0] !== 11'd19 || rec_maxy[0] !== 10'd9) begin
            n_err++;
            $display("FAIL basic_record: got %0d (%0d,%0d,%0d,%0d), required 3 (10,5,19,9)",
                     rec_label[0], rec_minx[0], rec_miny[0], rec_maxx[0], rec_maxy[0]);
        end
        n_vec++;
        if (done_count !== 8'd1 || done_ovf !== 1'b0) begin
            n_err++; $display("FAIL basic_count: count=%0d ovf=%b, required 1 0", done_count, done_ovf);
        end
        if (stall > 0) begin
            n_vec++;
            if (held !== stall || changed !== 0) begin
                n_err++; $display("FAIL stall_hold: held=%0d changed=%0d, required %0d 0", held, changed, stall);
            end
        end
        @(negedge clk); #1;
        n_vec++;
        if (frame_done !== 1'b0 || box_count !== 8'd1 || tbl_clr_en !== 1'b1) begin
            n_err++;
            $display("FAIL after_done: done=%b count=%0d clr=%b, required 0 1 1", frame_done, box_count, tbl_clr_en);
        end
    endtask

    task automatic test_overflow();
        wait_accept();
        clear_table();
        for (int i = 0; i < 20; i++) set_entry(3 * i, i, i + 2, 2, 3);
        min_w = 11'd1; min_h = 10'd1;
        send_frame(2, 1'b0);
        collect(0);
        n_vec++;
        if (rec_n !== 16) begin
            n_err++; $display("FAIL ovf_rec_n: got %0d, required 16", rec_n);
        end
        for (int i = 0; i < 16; i++) begin
            n_vec++;
            if (rec_label[i] !== LW'(3 * i) || rec_minx[i] !== XW'(i) || rec_maxx[i] !== XW'(i + 2) ||
                rec_miny[i] !== 10'd2 || rec_maxy[i] !== 10'd3) begin
                n_err++;
                $display("FAIL ovf_record[%0d]: label=%0d min_x=%0d, required %0d %0d", i, rec_label[i], rec_minx[i], 3 * i, i);
            end
        end
        n_vec++;
        if (done_count !== 8'd16 || done_ovf !== 1'b1) begin
            n_err++; $display("FAIL ovf_count: count=%0d ovf=%b, required 16 1", done_count, done_ovf);
        end
    endtask

    task automatic test_boundary();
        wait_accept();
        clear_table();
        set_entry(1, 100, 109, 20, 24);
        set_entry(2, 0, 8, 0, 4);
        set_entry(62, 5, 14, 1, 5);
        set_entry(63, 0, 9, 0, 3);
        t_minx[4] = 11'd0; t_maxx[4] = 11'd500; t_maxy[4] = 10'd500;
        min_w = 11'd10; min_h = 10'd5;
        send_frame(1, 1'b0);
        collect(0);
        n_vec++;
        if (rec_n !== 2 || rec_label[0] !== 6'd1 || rec_label[1] !== 6'd62) begin
            n_err++;
            $display("FAIL boundary_labels: n=%0d first=%0d second=%0d, required 2 1 62", rec_n, rec_label[0], rec_label[1]);
        end
        n_vec++;
        if (done_count !== 8'd2 || done_ovf !== 1'b0) begin
            n_err++; $display("FAIL boundary_count: count=%0d ovf=%b, required 2 0", done_count, done_ovf);
        end
    endtask

    task automatic test_full_span();
        wait_accept();
        clear_table();
        set_entry(9, 0, 2047, 0, 1023);
        set_entry(10, 1, 2047, 1, 1023);
        set_entry(11, 2, 2047, 0, 1023);
        min_w = 11'd2047; min_h = 10'd1023;
        send_frame(1, 1'b0);
        collect(0);
        n_vec++;
        if (rec_n !== 2 || rec_label[0] !== 6'd9 || rec_label[1] !== 6'd10 || done_count !== 8'd2) begin
            n_err++;
            $display("FAIL full_span: n=%0d labels=%0d,%0d count=%0d, required 2 9,10 2",
                     rec_n, rec_label[0], rec_label[1], done_count);
        end
    endtask

    task automatic test_min_zero();
        wait_accept();
        clear_table();
        set_entry(5, 7, 7, 3, 3);
        t_maxx[6] = 11'd300; t_maxy[6] = 10'd300;
        min_w = 11'd0; min_h = 10'd0;
        send_frame(1, 1'b0);
        collect(0);
        n_vec++;
        if (rec_n !== 1 || rec_label[0] !== 6'd5 || rec_minx[0] !== 11'd7 || done_count !== 8'd1) begin
            n_err++;
            $display("FAIL min_zero: n=%0d label=%0d min_x=%0d count=%0d, required 1 5 7 1",
                     rec_n, rec_label[0], rec_minx[0], done_count);
        end
    endtask

    task automatic test_reset_in_emit();
        int ok;
        wait_accept();
        clear_table();
        set_entry(3, 10, 19, 5, 9);
        min_w = 11'd4; min_h = 10'd2;
        box_ready = 1'b0;
        send_frame(3, 1'b0);
        ok = 0;
        for (int c = 0; c < 300 && ok == 0; c++) begin
            @(negedge clk); #1;
            if (box_valid === 1'b1) ok = 1;
        end
        n_vec++;
        if (ok == 0) begin
            n_err++; $display("FAIL emit_reach: box_valid=%b after 300 cycles, required 1", box_valid);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++;
        if (box_valid !== 1'b0 || box_count !== 8'd0 || tbl_clr_en !== 1'b1 || tbl_addr !== 6'd0) begin
            n_err++;
            $display("FAIL reset_emit: valid=%b count=%0d clr=%b addr=%0d, required 0 0 1 0",
                     box_valid, box_count, tbl_clr_en, tbl_addr);
        end
        ok = 1;
        for (int k = 1; k < NL; k++) begin
            @(negedge clk); #1;
            if (tbl_clr_en !== 1'b1 || tbl_addr !== LW'(k) || frame_done !== 1'b0) ok = 0;
        end
        n_vec++;
        if (ok == 0) begin
            n_err++; $display("FAIL reset_resweep: clr=%b addr=%0d done=%b, required 1 63 0", tbl_clr_en, tbl_addr, frame_done);
        end
        @(negedge clk); #1;
        n_vec++;
        if (pix_ready !== 1'b1 || frame_done !== 1'b0) begin
            n_err++; $display("FAIL reset_reaccept: ready=%b done=%b, required 1 0", pix_ready, frame_done);
        end
    endtask

    task automatic test_stream();
        int bad;
        wait_accept();
        clear_table();
        min_w = 11'd1; min_h = 10'd1;
        send_frame(100, 1'b1);
        collect(0);
        n_vec++;
        if (dp_cnt !== 100 || done_count !== 8'd0) begin
            n_err++; $display("FAIL stream_dp: dp_enable cycles=%0d count=%0d, required 100 0", dp_cnt, done_count);
        end
        bad = 0;
        for (int k = 0; k < NL; k++) begin
            @(negedge clk); #1;
            if (pix_ready !== 1'b0 || dp_enable !== 1'b0) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++; $display("FAIL stream_ready_low: %0d cycles with ready high during clear, required 0", bad);
        end
        @(negedge clk); #1;
        n_vec++;
        if (pix_ready !== 1'b1 || dp_enable !== 1'b1) begin
            n_err++; $display("FAIL stream_reaccept: ready=%b dp=%b, required 1 1", pix_ready, dp_enable);
        end
        pix_valid = 1'b0;
    endtask

    initial begin
        clear_table();
        test_reset();
        test_basic_filter(0);
        test_basic_filter(20);
        test_overflow();
        test_boundary();
        test_full_span();
        test_min_zero();
        test_reset_in_emit();
        test_stream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bbox_frame_sequencer.md
Name: bbox_frame_sequencer

Overview:
Sequences the per-frame bounding-box datapath in three phases.
- ACCEPT: gates the pixel stream into labeling/tracking.
- SCAN: at frame end, scans the per-label bbox table, filters boxes by minimum size and streams surviving boxes out over a valid/ready interface.
- CLEAR: clears the table before the next frame.
- Sits between the pixel source and the labeler/bbox tracker. Replaces the free-running "dump every label" output with backpressure-aware, filtered readout.

Parameters:
- WIDTH_BITS, 11, x coordinate width
- HEIGHT_BITS, 10, y coordinate width
- LABEL_WIDTH, 6, label index width
- NUM_LABELS, 1<<LABEL_WIDTH, table depth
- MAX_BOXES, 16, maximum boxes emitted per frame; must be ≤ 255

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- pix_valid  in  1  upstream pixel present
- pix_last  in  1  qualifies last pixel of frame
- pix_ready  out  1  sequencer accepts pixel
- dp_enable  out  1  datapath advance strobe = pix_valid & pix_ready
- min_w  in  WIDTH_BITS  minimum box width (inclusive)
- min_h  in  HEIGHT_BITS  minimum box height (inclusive)
- tbl_rd_en  out  1  table read strobe
- tbl_addr  out  LABEL_WIDTH  table read/clear address
- tbl_active  in  1  read data: label active (valid 1 cycle after tbl_rd_en)
- tbl_min_x, tbl_max_x  in  WIDTH_BITS  read data
- tbl_min_y, tbl_max_y  in  HEIGHT_BITS  read data
- tbl_clr_en  out  1  clear entry at tbl_addr (active<=0, bounds to reset values)
- box_valid  out  1  box record present
- box_ready  in  1  consumer accepts
- box_label  out  LABEL_WIDTH  label of record
- box_min_x, box_max_x  out  WIDTH_BITS  record bounds
- box_min_y, box_max_y  out  HEIGHT_BITS  record bounds
- frame_done  out  1  one-cycle pulse after scan completes
- box_count  out  8  boxes emitted this frame; valid with frame_done
- box_overflow  out  1  more than MAX_BOXES passed filter; valid with frame_done

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- States: CLEAR, ACCEPT, SCAN, CHK, EMIT, DONE.
- Reset: state=CLEAR, idx=0. All outputs 0, including box fields, box_count and box_overflow.
- CLEAR:
  - tbl_clr_en=1, tbl_addr=idx, pix_ready=0.
  - idx increments each cycle; after idx=NUM_LABELS-1, go to ACCEPT with idx=0.
  - Takes exactly NUM_LABELS cycles.
- ACCEPT:
  - pix_ready=1.
  - A cycle with pix_valid & pix_last & pix_ready moves to SCAN next cycle; the last pixel is still enabled that cycle.
  - pix_ready=0 from the following cycle until ACCEPT is re-entered.
  - Per-frame counters clear on ACCEPT entry.
- SCAN: tbl_rd_en=1, tbl_addr=idx; next state CHK.
- CHK:
  - Table data is valid this cycle.
  - Pass condition: tbl_active, (max_x-min_x+1) ≥ min_w, and (max_y-min_y+1) ≥ min_h.
  - Width math is WIDTH_BITS+1 / HEIGHT_BITS+1 bits, no wrap.
  - Pass and count<MAX_BOXES: register the record into box_* and go to EMIT.
  - Pass and count=MAX_BOXES: set the overflow flag and skip the box.
  - Otherwise, or after a skip: if idx=NUM_LABELS-1 go to DONE, else idx++ and return to SCAN.
  - An inactive label costs 2 cycles.
- EMIT:
  - box_valid=1 with box_* held stable until box_ready.
  - On valid&ready: count++, box_valid=0 next cycle, then next idx or DONE as in CHK.
  - box_valid never deasserts without a handshake.
- DONE: frame_done=1 for one cycle with box_count and box_overflow; next state CLEAR, idx=0.
- Between frames: box_count and box_overflow hold until the next frame_done.
- pix_valid while pix_ready=0 is ignored; upstream must hold.
- Reset mid-operation (any state): abandon the frame, drop box_valid immediately next cycle, restart in CLEAR.
- min_w=0 or min_h=0: every active label passes. Inputs are sampled in CHK; changing them mid-scan is allowed.
- Simultaneous box_ready in the same cycle box_valid rises counts as a handshake.

Decomposition:
- Package bbox_pkg holds:
  - state enum seq_state_t
  - struct bbox_rec_t {label, min_x, min_y, max_x, max_y}
  - localparam COUNT_W=8
- Sub-module bbox_size_filter (combinational): table entry + min_w/min_h -> pass. Instantiated once in CHK logic.

Test Plan:
1. Reset release with NUM_LABELS=64 -> tbl_clr_en high 64 cycles, addresses 0..63. pix_ready rises on cycle 65.
2. Labels 3 (x 10..19, y 5..9) and 7 (x 0..1, y 0..0) active; min_w=4, min_h=2 -> one record label=3, (10,5,19,9); box_count=1, box_overflow=0.
3. Same as scenario 2 with box_ready low 20 cycles -> box_valid held 20 cycles, fields constant, exactly one record.
4. MAX_BOXES=16; 20 active labels all passing -> 16 records for labels in ascending order, box_count=16, box_overflow=1.
5. pix_valid=1 every cycle, pix_last on pixel 100 -> dp_enable high 100 cycles, pix_ready low the cycle after pixel 100, high again only after DONE+CLEAR.
6. rst asserted during EMIT -> box_valid=0 next cycle, CLEAR sweep repeats, no frame_done for the aborted frame.
